// File: rtl/ddmtd_pkg.sv
// rtl/ddmtd_pkg.sv - shared state type and parameter defaults for the DDMTD sampler
package ddmtd_pkg;

    localparam int DEF_N_CH        = 2;
    localparam int DEF_SYNC_STAGES = 3;
    localparam int DEF_GLITCH_THR  = 4;
    localparam int DEF_TAG_W       = 16;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_LOW,
        ST_RISE_CHK,
        ST_HIGH,
        ST_FALL_CHK
    } ddmtd_state_e;

endpackage

// File: rtl/ddmtd_deglitcher.sv
// rtl/ddmtd_deglitcher.sv - one channel: sync chain, deglitch FSM and tag register
module ddmtd_deglitcher
    import ddmtd_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int GLITCH_THR  = DEF_GLITCH_THR,
    parameter int TAG_W       = DEF_TAG_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clk_in_i,
    input  logic             en_i,
    input  logic [TAG_W-1:0] ts_i,
    input  logic             tag_ready_i,
    input  logic             ovf_clr_i,
    output logic             sampled_o,
    output logic             filt_o,
    output logic             tag_valid_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             tag_ovf_o
);

    localparam int CNT_W = $clog2(GLITCH_THR + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    ddmtd_state_e           state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TAG_W-1:0]       cap_q, cap_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;

    logic                   sample;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   thr_hit;
    logic                   emit;
    logic                   accept;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], clk_in_i};
        sample  = sync_q[SYNC_STAGES-1];
        cnt_inc = cnt_q + CNT_W'(1);
        thr_hit = (cnt_inc == CNT_W'(GLITCH_THR));
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        emit    = 1'b0;

        case (state_q)
            // ARM insists on a clean low run so a clock already high at
            // reset/enable never produces a bogus rising edge
            ST_ARM: begin
                if (sample) begin
                    cnt_d = '0;
                end else if (thr_hit) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_LOW: begin
                if (sample) begin
                    state_d = ST_RISE_CHK;
                    cnt_d   = CNT_W'(1);
                    cap_d   = ts_i;
                end
            end
            ST_RISE_CHK: begin
                if (!sample) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (thr_hit) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    emit    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HIGH: begin
                if (!sample) begin
                    state_d = ST_FALL_CHK;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_FALL_CHK: begin
                if (sample) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (thr_hit) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_ARM;
                cnt_d   = '0;
            end
        endcase

        if (!en_i) begin
            state_d = ST_ARM;
            cnt_d   = '0;
            emit    = 1'b0;
        end
    end

    always_comb begin
        accept  = valid_q & tag_ready_i;
        tag_d   = tag_q;
        valid_d = valid_q;
        ovf_d   = ovf_q & ~ovf_clr_i;
        if (accept) begin
            valid_d = 1'b0;
        end
        // a tag arriving into an occupied, unaccepted slot is dropped
        if (emit) begin
            if (!valid_q || accept) begin
                tag_d   = cap_q;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (!en_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            state_q <= ST_ARM;
            cnt_q   <= '0;
            cap_q   <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sampled_o   = sync_q[SYNC_STAGES-1];
    assign filt_o      = (state_q == ST_HIGH) || (state_q == ST_FALL_CHK);
    assign tag_valid_o = valid_q;
    assign tag_o       = tag_q;
    assign tag_ovf_o   = ovf_q;

endmodule

// File: rtl/ddmtd_multi_sampler.sv
// rtl/ddmtd_multi_sampler.sv - multi-channel DDMTD sampler with shared timestamp counter
module ddmtd_multi_sampler
    import ddmtd_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int GLITCH_THR  = DEF_GLITCH_THR,
    parameter int TAG_W       = DEF_TAG_W
) (
    input  logic                  clk_ddmtd_i,
    input  logic                  rst_ddmtdclk_i,
    input  logic [N_CH-1:0]       clk_in_i,
    input  logic [N_CH-1:0]       en_i,
    output logic [N_CH-1:0]       clk_sampled_o,
    output logic [N_CH-1:0]       clk_filt_o,
    output logic [N_CH-1:0]       tag_valid_o,
    input  logic [N_CH-1:0]       tag_ready_i,
    output logic [N_CH*TAG_W-1:0] tag_o,
    output logic [N_CH-1:0]       tag_ovf_o,
    input  logic                  ovf_clr_i
);

    logic [TAG_W-1:0] ts_q, ts_d;

    always_comb begin
        ts_d = ts_q + TAG_W'(1);
    end

    always_ff @(posedge clk_ddmtd_i or posedge rst_ddmtdclk_i) begin
        if (rst_ddmtdclk_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        ddmtd_deglitcher #(
            .SYNC_STAGES(SYNC_STAGES),
            .GLITCH_THR (GLITCH_THR),
            .TAG_W      (TAG_W)
        ) u_deglitcher (
            .clk_i      (clk_ddmtd_i),
            .rst_i      (rst_ddmtdclk_i),
            .clk_in_i   (clk_in_i[k]),
            .en_i       (en_i[k]),
            .ts_i       (ts_q),
            .tag_ready_i(tag_ready_i[k]),
            .ovf_clr_i  (ovf_clr_i),
            .sampled_o  (clk_sampled_o[k]),
            .filt_o     (clk_filt_o[k]),
            .tag_valid_o(tag_valid_o[k]),
            .tag_o      (tag_o[k*TAG_W +: TAG_W]),
            .tag_ovf_o  (tag_ovf_o[k])
        );
    end

endmodule

// File: tb/tb_ddmtd_multi_sampler.sv
// tb/tb_ddmtd_multi_sampler.sv - directed table-driven bench for ddmtd_multi_sampler
module tb_ddmtd_multi_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  clk_in;
    logic [1:0]  en;
    logic [1:0]  sampled;
    logic [1:0]  filt;
    logic [1:0]  tag_valid;
    logic [1:0]  tag_ready;
    logic [31:0] tag;
    logic [1:0]  tag_ovf;
    logic        ovf_clr;

    int          passed = 0;
    int          total  = 0;
    logic [15:0] tsm;
    logic [15:0] tq[$];

    typedef struct {
        logic in0;
        logic exp_sampled;
        logic exp_filt;
        logic exp_valid;
    } vec_t;

    vec_t vecs[1:40];

    always #5 clk = ~clk;

    ddmtd_multi_sampler #(
        .N_CH(2), .SYNC_STAGES(3), .GLITCH_THR(4), .TAG_W(16)
    ) dut (
        .clk_ddmtd_i   (clk),
        .rst_ddmtdclk_i(rst),
        .clk_in_i      (clk_in),
        .en_i          (en),
        .clk_sampled_o (sampled),
        .clk_filt_o    (filt),
        .tag_valid_o   (tag_valid),
        .tag_ready_i   (tag_ready),
        .tag_o         (tag),
        .tag_ovf_o     (tag_ovf),
        .ovf_clr_i     (ovf_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tsm = tsm + 16'd1;
    endtask

    task automatic run(input logic v, input int n);
        clk_in[0] = v;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tag_valid[0]) tq.push_back(tag[15:0]);
        end
    endtask

    initial begin
        logic [15:0] t1, t2;
        logic [15:0] exp_tags[3];
        int          guard;

        rst = 1'b1; clk_in = 2'b00; en = 2'b01; tag_ready = 2'b11; ovf_clr = 1'b0; tsm = '0;
        tick(); tick();
        check("rst_sampled", 32'(sampled), 0);
        check("rst_filt",    32'(filt),    0);
        check("rst_valid",   32'(tag_valid), 0);
        check("rst_tag",     tag,          0);
        check("rst_ovf",     32'(tag_ovf), 0);
        rst = 1'b0;
        tsm = '0;

        // pulse 3 samples, clean rise, 1-sample dropout, fall
        for (int i = 1; i <= 40; i++) begin
            vecs[i].in0         = (i >= 5 && i <= 7) || (i >= 12 && i <= 25) || (i >= 27 && i <= 30);
            vecs[i].exp_sampled = (i >= 7 && i <= 9) || (i >= 14 && i <= 27) || (i >= 29 && i <= 32);
            vecs[i].exp_filt    = (i >= 18 && i <= 36);
            vecs[i].exp_valid   = (i == 18);
        end
        for (int i = 1; i <= 40; i++) begin
            clk_in = {vecs[i].in0, vecs[i].in0};
            tick();
            check($sformatf("tbl_sampled0[%0d]", i), 32'(sampled[0]),   32'(vecs[i].exp_sampled));
            check($sformatf("tbl_filt0[%0d]", i),    32'(filt[0]),      32'(vecs[i].exp_filt));
            check($sformatf("tbl_valid0[%0d]", i),   32'(tag_valid[0]), 32'(vecs[i].exp_valid));
            check($sformatf("tbl_sampled1[%0d]", i), 32'(sampled[1]),   32'(vecs[i].exp_sampled));
            check($sformatf("tbl_dis_filt1[%0d]", i), 32'(filt[1]),     0);
            check($sformatf("tbl_dis_valid1[%0d]", i), 32'(tag_valid[1]), 0);
            if (i == 18) check("tbl_tag0", 32'(tag[15:0]), 32'h000E);
        end
        clk_in[1] = 1'b0;

        // square wave, period 20
        tq.delete();
        for (int p = 0; p < 3; p++) begin
            exp_tags[p] = tsm + 16'd3;
            run(1'b1, 6);
            check($sformatf("sq_filt_lag6[%0d]", p), 32'(filt[0]), 0);
            run(1'b1, 1);
            check($sformatf("sq_filt_lag7[%0d]", p), 32'(filt[0]), 1);
            run(1'b1, 3);
            run(1'b0, 10);
        end
        check("sq_ntags", tq.size(), 3);
        if (tq.size() == 3) begin
            for (int p = 0; p < 3; p++) check($sformatf("sq_tag[%0d]", p), 32'(tq[p]), 32'(exp_tags[p]));
            for (int p = 1; p < 3; p++) check($sformatf("sq_space[%0d]", p), 32'(tq[p] - tq[p-1]), 20);
        end

        // backpressure and overflow
        tag_ready[0] = 1'b0;
        t1 = tsm + 16'd3;
        run(1'b1, 10); run(1'b0, 10);
        check("bp_valid1", 32'(tag_valid[0]), 1);
        check("bp_tag1",   32'(tag[15:0]),    32'(t1));
        check("bp_ovf0",   32'(tag_ovf[0]),   0);
        run(1'b1, 10); run(1'b0, 10);
        check("bp_tag_hold", 32'(tag[15:0]),  32'(t1));
        check("bp_ovf1",     32'(tag_ovf[0]), 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_clr",       32'(tag_ovf[0]),   0);
        check("ovf_clr_valid", 32'(tag_valid[0]), 1);
        run(1'b1, 6);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(tag_ovf[0]), 1);
        run(1'b1, 3); run(1'b0, 10);
        check("ovf_tag_hold", 32'(tag[15:0]), 32'(t1));
        t2 = tsm + 16'd3;
        run(1'b1, 6);
        tag_ready[0] = 1'b1; tick();
        check("acc_load_valid", 32'(tag_valid[0]), 1);
        check("acc_load_tag",   32'(tag[15:0]),    32'(t2));
        check("acc_load_ovf",   32'(tag_ovf[0]),   1);
        tick();
        check("acc_drop_valid", 32'(tag_valid[0]), 0);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        run(1'b1, 3); run(1'b0, 10);

        // wrap of the timestamp counter
        guard = 0;
        while (tsm != 16'hFFFB && guard < 70000) begin
            tick();
            guard++;
        end
        check("wrap_reach", 32'(tsm == 16'hFFFB), 1);
        tq.delete();
        run(1'b1, 10); run(1'b0, 10); run(1'b1, 10); run(1'b0, 10);
        check("wrap_ntags", tq.size(), 2);
        if (tq.size() == 2) begin
            check("wrap_tag0", 32'(tq[0]), 32'hFFFE);
            check("wrap_tag1", 32'(tq[1]), 32'h0012);
        end

        // async reset during RISE_CHK, then re-arm from a high input
        run(1'b1, 4);
        rst = 1'b1;
        #1;
        check("mid_rst_sampled", 32'(sampled),   0);
        check("mid_rst_filt",    32'(filt),      0);
        check("mid_rst_valid",   32'(tag_valid), 0);
        check("mid_rst_tag",     tag,            0);
        check("mid_rst_ovf",     32'(tag_ovf),   0);
        #1;
        rst = 1'b0;
        tsm = '0;
        tq.delete();
        run(1'b1, 10);
        check("rearm_no_tag_high", tq.size(), 0);
        check("rearm_filt_high",   32'(filt[0]), 0);
        run(1'b0, 10);
        check("rearm_no_tag_low", tq.size(), 0);
        run(1'b1, 10);
        check("rearm_ntags", tq.size(), 1);
        if (tq.size() == 1) check("rearm_tag", 32'(tq[0]), 32'd23);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
